grid_io_param: RTL and testbench
================================

GRID_IO_PARAM -- requirements
Module: grid_io_param

Interface
REQ-001 SHALL have parameter NUM_IO, default 8: number of IO subtiles, range 1..64.
REQ-002 SHALL have derived constant L = 2*NUM_IO: configuration chain length, 2 bits per subtile.
REQ-003 SHALL have port prog_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port prog_reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port cfg_done, input, 1 bit: configuration-complete level.
REQ-006 SHALL have port ccff_shift_en, input, 1 bit: shift qualifier for the configuration chain.
REQ-007 SHALL have port ccff_head, input, 1 bit: serial configuration data in.
REQ-008 SHALL have port ccff_tail, output, 1 bit: serial configuration data out.
REQ-009 SHALL have port outpad, input, NUM_IO bits: fabric-to-pad data, bit k = subtile k.
REQ-010 SHALL have port inpad, output, NUM_IO bits: pad-to-fabric data.
REQ-011 SHALL have port gpio_pad_in, input, NUM_IO bits: pad receiver value.
REQ-012 SHALL have port gpio_pad_out, output, NUM_IO bits: pad driver data.
REQ-013 SHALL have port gpio_pad_oe, output, NUM_IO bits: pad driver enable, 1 = drive.
REQ-014 SHALL have port cfg_count, output, clog2(L+1) bits: number of accepted shifts, saturating.
REQ-015 SHALL have port cfg_loaded, output, 1 bit: high when cfg_count == L.
REQ-016 SHALL have port cfg_active, output, 1 bit: committed configuration drives the pads.

Function
REQ-017 SHALL hold an L-bit shift register sr; an accepted shift (ccff_shift_en=1 AND cfg_done=0) sets sr <= {sr[L-2:0], ccff_head}.
REQ-018 SHALL drive ccff_tail = sr[L-1], a flop output, so a head bit appears on the tail after exactly L accepted shifts.
REQ-019 SHALL ignore ccff_shift_en while cfg_done=1; sr and cfg_count hold.
REQ-020 SHALL increment cfg_count on each accepted shift, saturate at L, and never wrap; cfg_loaded = (cfg_count == L), combinational from the counter.
REQ-021 SHALL register cfg_done into cfg_done_q; rise = cfg_done & ~cfg_done_q, fall = ~cfg_done & cfg_done_q.
REQ-022 SHALL, on rise, copy sr into an L-bit shadow register and set cfg_active=1, both visible the cycle after the rising edge is sampled.
REQ-023 SHALL commit on rise even when cfg_loaded=0; a partial chain commits as-is.
REQ-024 SHALL, on fall, clear cfg_active and cfg_count to 0 and retain both shadow and sr.
REQ-025 SHALL map subtile k as: shadow[2k] = oe_cfg, shadow[2k+1] = invert; the first bit shifted in after reset lands in subtile NUM_IO-1's invert bit.
REQ-026 SHALL drive gpio_pad_oe[k] = cfg_active & oe_cfg[k] (combinational).
REQ-027 SHALL drive gpio_pad_out[k] = outpad[k] ^ invert[k] (combinational).
REQ-028 SHALL drive inpad[k] = (gpio_pad_in[k] ^ invert[k]) when cfg_active=1 and oe_cfg[k]=0, else 0 (combinational).
REQ-029 SHALL give a commit priority over a shift when both occur in the same cycle; the shift is blocked by REQ-019, so shadow captures the pre-edge sr.

Reset
REQ-030 SHALL, while prog_reset=0 at a clock edge, clear sr, shadow, cfg_count, cfg_done_q and cfg_active to 0, including mid-shift and mid-commit.
REQ-031 SHALL therefore present after reset: ccff_tail=0, cfg_loaded=0, gpio_pad_oe=0, inpad=0, gpio_pad_out=outpad.
REQ-032 SHALL treat cfg_done already high at reset release as a rise on the first active cycle, committing sr (all zero).

Verification (NUM_IO=8, L=16)
REQ-033 SHALL cover: reset asserted after 5 shifts -> next cycle cfg_count=0, ccff_tail=0, gpio_pad_oe=8'h00, inpad=8'h00.
REQ-034 SHALL cover: shift 14 zeros then 1,1, raise cfg_done -> one cycle later cfg_active=1, gpio_pad_oe=8'h01; outpad[0]=1 gives gpio_pad_out[0]=0.
REQ-035 SHALL cover: after reset shift 1 then 16 zeros -> ccff_tail=1 exactly after the 16th shift and 0 after the 17th; cfg_count stays at 16.
REQ-036 SHALL cover: cfg_done=1 with ccff_shift_en=1 for 4 cycles -> sr, cfg_count and ccff_tail unchanged.
REQ-037 SHALL cover: with sr all zero committed, gpio_pad_in[3]=1 -> inpad[3]=1; then drop cfg_done -> next cycle inpad=8'h00, cfg_count=0, cfg_active=0.
REQ-038 SHALL cover: cfg_done rising in the same cycle as a shift request -> shadow equals the pre-edge sr; cfg_count unchanged.

Source files
------------

// File: rtl/grid_io_param.sv
// IO grid tile: serial configuration chain with commit-on-rise shadow register
// and per-subtile pad control (output enable and data inversion).
module grid_io_param #(
  parameter int NUM_IO = 8
) (
  input  logic                            prog_clk,
  input  logic                            prog_reset,
  input  logic                            cfg_done,
  input  logic                            ccff_shift_en,
  input  logic                            ccff_head,
  output logic                            ccff_tail,
  input  logic [NUM_IO-1:0]               outpad,
  output logic [NUM_IO-1:0]               inpad,
  input  logic [NUM_IO-1:0]               gpio_pad_in,
  output logic [NUM_IO-1:0]               gpio_pad_out,
  output logic [NUM_IO-1:0]               gpio_pad_oe,
  output logic [$clog2(2*NUM_IO+1)-1:0]   cfg_count,
  output logic                            cfg_loaded,
  output logic                            cfg_active
);

  localparam int L  = 2 * NUM_IO;
  localparam int CW = $clog2(L + 1);

  logic [L-1:0]  sr_q, sr_d;
  logic [L-1:0]  shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          active_q, active_d;

  logic cfg_rise, cfg_fall, shift_ok;

  assign cfg_rise = cfg_done & ~done_q;
  assign cfg_fall = ~cfg_done & done_q;
  // A committed configuration is frozen: shifting is only accepted while cfg_done is low.
  assign shift_ok = ccff_shift_en & ~cfg_done;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    sr_d     = sr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = cfg_done;
    active_d = active_q;
    if (shift_ok) begin
      sr_d = {sr_q[L-2:0], ccff_head};
      if (cnt_q != CW'(L)) cnt_d = cnt_q + CW'(1);
    end
    if (cfg_rise) begin
      shadow_d = sr_q;
      active_d = 1'b1;
    end
    if (cfg_fall) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      sr_q     <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign ccff_tail  = sr_q[L-1];
  assign cfg_count  = cnt_q;
  assign cfg_loaded = (cnt_q == CW'(L));
  assign cfg_active = active_q;

  // Subtile k owns shadow bits {2k+1: invert, 2k: output enable}.
  always_comb begin
    gpio_pad_oe  = '0;
    gpio_pad_out = '0;
    inpad        = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      gpio_pad_oe[k]  = active_q & shadow_q[2*k];
      gpio_pad_out[k] = outpad[k] ^ shadow_q[2*k+1];
      inpad[k]        = (active_q & ~shadow_q[2*k]) & (gpio_pad_in[k] ^ shadow_q[2*k+1]);
    end
  end

endmodule

// File: tb/tb_grid_io_param.sv
// Self-checking bench for grid_io_param (NUM_IO=8): per-cycle scoreboard of a
// reference model plus directed scenario checks.
module tb_grid_io_param;

  localparam int N = 8;
  localparam int L = 16;

  logic         prog_clk;
  logic         prog_reset;
  logic         cfg_done;
  logic         ccff_shift_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [N-1:0] outpad;
  logic [N-1:0] inpad;
  logic [N-1:0] gpio_pad_in;
  logic [N-1:0] gpio_pad_out;
  logic [N-1:0] gpio_pad_oe;
  logic [4:0]   cfg_count;
  logic         cfg_loaded;
  logic         cfg_active;

  grid_io_param #(.NUM_IO(N)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .cfg_done      (cfg_done),
    .ccff_shift_en (ccff_shift_en),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .outpad        (outpad),
    .inpad         (inpad),
    .gpio_pad_in   (gpio_pad_in),
    .gpio_pad_out  (gpio_pad_out),
    .gpio_pad_oe   (gpio_pad_oe),
    .cfg_count     (cfg_count),
    .cfg_loaded    (cfg_loaded),
    .cfg_active    (cfg_active)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  typedef struct packed {
    logic         tail;
    logic [4:0]   cnt;
    logic         loaded;
    logic         active;
    logic [N-1:0] oe;
    logic [N-1:0] pout;
    logic [N-1:0] inp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [L-1:0] m_sr, m_sh;
  logic [4:0]   m_cnt;
  logic         m_act, m_dq;

  function automatic exp_t model_out();
    exp_t e;
    e.tail   = m_sr[L-1];
    e.cnt    = m_cnt;
    e.loaded = (m_cnt == 5'd16);
    e.active = m_act;
    for (int k = 0; k < N; k++) begin
      e.oe[k]   = m_act & m_sh[2*k];
      e.pout[k] = outpad[k] ^ m_sh[2*k+1];
      e.inp[k]  = (m_act && !m_sh[2*k]) ? (gpio_pad_in[k] ^ m_sh[2*k+1]) : 1'b0;
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic done, input logic shen, input logic head);
    exp_t e, got;
    logic rise, fall;
    @(negedge prog_clk);
    prog_reset = rst; cfg_done = done; ccff_shift_en = shen; ccff_head = head;
    if (!rst) begin
      m_sr = '0; m_sh = '0; m_cnt = '0; m_act = 1'b0; m_dq = 1'b0;
    end else begin
      rise = done & ~m_dq;
      fall = ~done & m_dq;
      if (rise) begin
        m_sh  = m_sr;
        m_act = 1'b1;
      end
      if (shen && !done) begin
        m_sr = {m_sr[L-2:0], head};
        if (m_cnt < 5'd16) m_cnt = m_cnt + 5'd1;
      end
      if (fall) begin
        m_act = 1'b0;
        m_cnt = '0;
      end
      m_dq = done;
    end
    exp_q.push_back(model_out());
    @(posedge prog_clk);
    #1;
    e   = exp_q.pop_front();
    got = '{ccff_tail, cfg_count, cfg_loaded, cfg_active, gpio_pad_oe, gpio_pad_out, inpad};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, got, e);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, req);
    end
  endtask

  task automatic test_reset();
    outpad = 8'h5A; gpio_pad_in = 8'hFF;
    do_reset();
    chk("reset_count", 16'(cfg_count), 16'd0);
    chk("reset_tail", 16'(ccff_tail), 16'd0);
    chk("reset_loaded", 16'(cfg_loaded), 16'd0);
    chk("reset_oe", 16'(gpio_pad_oe), 16'h00);
    chk("reset_inpad", 16'(inpad), 16'h00);
    chk("reset_padout", 16'(gpio_pad_out), 16'h5A);
    // cfg_done already high across reset release commits all-zero sr
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("release_rise_active", 16'(cfg_active), 16'd1);
    chk("release_rise_inpad", 16'(inpad), 16'hFF);
  endtask

  task automatic test_mid_reset();
    outpad = 8'h00; gpio_pad_in = 8'h00;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("pre_reset_count", 16'(cfg_count), 16'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("mid_reset_count", 16'(cfg_count), 16'd0);
    chk("mid_reset_tail", 16'(ccff_tail), 16'd0);
    chk("mid_reset_oe", 16'(gpio_pad_oe), 16'h00);
    chk("mid_reset_inpad", 16'(inpad), 16'h00);
  endtask

  task automatic test_commit_and_hold();
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("commit_pre_active", 16'(cfg_active), 16'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("commit_active", 16'(cfg_active), 16'd1);
    chk("commit_oe", 16'(gpio_pad_oe), 16'h01);
    outpad = 8'h01;
    #1;
    chk("commit_invert_out0", 16'(gpio_pad_out[0]), 16'd0);
    // Shift requests ignored while cfg_done is high
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("hold_count", 16'(cfg_count), 16'd16);
      chk("hold_tail", 16'(ccff_tail), 16'd0);
    end
    chk("hold_oe", 16'(gpio_pad_oe), 16'h01);
    outpad = 8'h00;
  endtask

  task automatic test_chain_latency();
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 15) chk("tail_before_16", 16'(ccff_tail), 16'd0);
    end
    chk("tail_at_16", 16'(ccff_tail), 16'd1);
    chk("loaded_at_16", 16'(cfg_loaded), 16'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("tail_at_17", 16'(ccff_tail), 16'd0);
    chk("count_saturated", 16'(cfg_count), 16'd16);
  endtask

  task automatic test_input_path_and_fall();
    gpio_pad_in = 8'h00;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    gpio_pad_in = 8'h08;
    #1;
    chk("inpad_bit3", 16'(inpad), 16'h08);
    chk("partial_count", 16'(cfg_count), 16'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fall_inpad", 16'(inpad), 16'h00);
    chk("fall_count", 16'(cfg_count), 16'd0);
    chk("fall_active", 16'(cfg_active), 16'd0);
    gpio_pad_in = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    pat = 16'h5A3C;
    outpad = 8'h00;
    do_reset();
    for (int i = 15; i >= 0; i--) step(1'b1, 1'b0, 1'b1, pat[i]);
    // Rise and shift request in the same cycle: shadow gets pre-edge sr
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("same_cycle_oe", 16'(gpio_pad_oe), 16'hC6);
    chk("same_cycle_invert", 16'(gpio_pad_out), 16'h36);
    chk("same_cycle_tail", 16'(ccff_tail), 16'd0);
    chk("same_cycle_count", 16'(cfg_count), 16'd16);
  endtask

  initial begin
    prog_reset = 1'b0; cfg_done = 1'b0; ccff_shift_en = 1'b0; ccff_head = 1'b0;
    outpad = '0; gpio_pad_in = '0;
    m_sr = '0; m_sh = '0; m_cnt = '0; m_act = 1'b0; m_dq = 1'b0;
    test_reset();
    test_mid_reset();
    test_commit_and_hold();
    test_chain_latency();
    test_input_path_and_fall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
